// File: rtl/fuzz_stim_pkg.sv
// Shared constants, state type and LCG step for the fuzz stimulus sequencer.
package fuzz_stim_pkg;

   localparam int RNG_W = 32;
   localparam logic [RNG_W-1:0] LCG_MUL = 32'h41C6_4E6D;
   localparam logic [RNG_W-1:0] LCG_INC = 32'h0000_3039;

   typedef enum logic [2:0] {
      IDLE,
      DRST,
      FILL,
      PRESENT,
      DONE
   } stim_state_t;

   // Product is evaluated at RNG_W bits, so the result is already mod 2^32.
   function automatic logic [RNG_W-1:0] lcg_next(input logic [RNG_W-1:0] cur);
      return cur * LCG_MUL + LCG_INC;
   endfunction

endpackage

// File: rtl/fuzz_lcg32.sv
// 32-bit LCG register: loads a seed or advances one step per request.
module fuzz_lcg32
   import fuzz_stim_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [RNG_W-1:0] load_val,
   input  logic             step,
   output logic [RNG_W-1:0] state_o,
   output logic [RNG_W-1:0] next_o
);

   logic [RNG_W-1:0] rng;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rng <= '0;
      end else if (load) begin
         rng <= load_val;
      end else if (step) begin
         rng <= next_o;
      end
   end

   assign state_o = rng;
   assign next_o  = lcg_next(rng);

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Holds the DUT in reset for a window, then fills IN_W-bit vectors 32 bits per
// cycle from the LCG and presents them on a valid/ready port until the count is met.
module fuzz_stim_sequencer
   import fuzz_stim_pkg::*;
#(
   parameter int IN_W    = 257,
   parameter int CNT_W   = 32,
   parameter int RST_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      seed,
   input  logic [CNT_W-1:0] num_vecs,
   output logic             dut_rst_n,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [IN_W-1:0]  vec_data,
   output logic [CNT_W-1:0] vec_cnt,
   output logic             busy,
   output logic             done
);

   localparam int NCHUNK = (IN_W + 31) / 32;
   localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int RCTR_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NCHUNK - 1);
   localparam logic [RCTR_W-1:0] LAST_RST   = RCTR_W'(RST_CYC - 1);

   stim_state_t state, state_nx;

   logic              accept;
   logic              fill_wr;
   logic              handshake;
   logic [CNT_W-1:0]  num_reg;
   logic [RCTR_W-1:0] rst_ctr;
   logic [CIDX_W-1:0] chunk_idx;
   logic [RNG_W-1:0]  rng_state_unused;
   logic [RNG_W-1:0]  rng_nx;
   logic [IN_W-1:0]   chunk_word;
   logic [IN_W-1:0]   chunk_mask;
   int unsigned       shamt;

   // abort always wins over start, and start is only honoured when not busy.
   assign accept    = start && !abort && ((state == IDLE) || (state == DONE));
   assign fill_wr   = (state == FILL) && !abort;
   assign handshake = (state == PRESENT) && vec_ready && !abort;

   fuzz_lcg32 u_lcg (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (seed),
      .step     (fill_wr),
      .state_o  (rng_state_unused),
      .next_o   (rng_nx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) state_nx = DRST;
            end
            DRST: begin
               if (rst_ctr == LAST_RST) state_nx = (num_reg == '0) ? DONE : FILL;
            end
            FILL: begin
               if (chunk_idx == LAST_CHUNK) state_nx = PRESENT;
            end
            PRESENT: begin
               if (vec_ready) state_nx = (vec_cnt + CNT_W'(1) == num_reg) ? DONE : FILL;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      dut_rst_n = 1'b0;
      vec_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         DRST: begin
            busy = 1'b1;
         end
         FILL: begin
            dut_rst_n = 1'b1;
            busy      = 1'b1;
         end
         PRESENT: begin
            dut_rst_n = 1'b1;
            vec_valid = 1'b1;
            busy      = 1'b1;
         end
         DONE: begin
            dut_rst_n = 1'b1;
            done      = 1'b1;
         end
         default: ;
      endcase
   end

   // The last chunk is truncated for free by shifting inside the IN_W-bit domain.
   always_comb begin
      shamt      = 32 * 32'(chunk_idx);
      chunk_word = IN_W'(rng_nx) << shamt;
      chunk_mask = IN_W'(32'hFFFF_FFFF) << shamt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_reg   <= '0;
         vec_cnt   <= '0;
         rst_ctr   <= '0;
         chunk_idx <= '0;
         vec_data  <= '0;
      end else begin
         if (accept) begin
            num_reg  <= num_vecs;
            vec_cnt  <= '0;
            rst_ctr  <= '0;
            vec_data <= '0;
         end
         if ((state == DRST) && !abort) begin
            rst_ctr <= rst_ctr + RCTR_W'(1);
         end
         if (fill_wr) begin
            vec_data  <= (vec_data & ~chunk_mask) | chunk_word;
            chunk_idx <= (chunk_idx == LAST_CHUNK) ? '0 : chunk_idx + CIDX_W'(1);
         end else begin
            chunk_idx <= '0;
         end
         if (handshake) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Bench for fuzz_stim_sequencer: per-cycle comparison against a timeline model
// of a run, plus literal expectations for the documented scenarios.
module tb_fuzz_stim_sequencer;

   localparam int IN_W    = 257;
   localparam int CNT_W   = 32;
   localparam int RST_CYC = 2;
   localparam int NCH     = (IN_W + 31) / 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [31:0]      seed;
   logic [CNT_W-1:0] num_vecs;
   logic             dut_rst_n;
   logic             vec_valid;
   logic             vec_ready;
   logic [IN_W-1:0]  vec_data;
   logic [CNT_W-1:0] vec_cnt;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   fuzz_stim_sequencer #(
      .IN_W    (IN_W),
      .CNT_W   (CNT_W),
      .RST_CYC (RST_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .seed      (seed),
      .num_vecs  (num_vecs),
      .dut_rst_n (dut_rst_n),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec_data  (vec_data),
      .vec_cnt   (vec_cnt),
      .busy      (busy),
      .done      (done)
   );

   int n_pass  = 0;
   int n_total = 0;

   function automatic void check(input string name, input logic [IN_W-1:0] act,
                                 input logic [IN_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endfunction

   // Run model: a run is a reset window, then per vector NCH fill cycles and
   // a presentation that lasts until the consumer takes it.
   bit                 m_busy, m_done;
   int                 m_rst_left, m_wait;
   logic [31:0]        m_rng;
   logic [CNT_W-1:0]   m_cnt, m_target;
   logic [IN_W-1:0]    m_vec;
   logic [NCH*32-1:0]  m_wide;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_rst_left = 0; m_wait = 0;
         m_rng = '0; m_cnt = '0; m_target = '0; m_vec = '0;
      end else if (abort) begin
         m_busy = 0; m_done = 0; m_rst_left = 0; m_wait = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_done = 0; m_rst_left = RST_CYC; m_wait = NCH;
            m_rng = seed; m_cnt = '0; m_target = num_vecs; m_vec = '0;
         end
      end else if (m_rst_left > 0) begin
         m_rst_left--;
         if (m_rst_left == 0 && m_target == 0) begin
            m_busy = 0; m_done = 1;
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            for (int k = 0; k < NCH; k++) begin
               m_rng = m_rng * 32'd1103515245 + 32'd12345;
               m_wide[32*k +: 32] = m_rng;
            end
            m_vec = m_wide[IN_W-1:0];
         end
      end else if (vec_ready) begin
         m_cnt++;
         if (m_cnt == m_target) begin
            m_busy = 0; m_done = 1;
         end else begin
            m_wait = NCH;
         end
      end
   end

   always @(negedge clk) begin
      bit mv;
      if (!rst) begin
         mv = m_busy && (m_rst_left == 0) && (m_wait == 0);
         check("cyc_busy", busy, m_busy);
         check("cyc_done", done, m_done);
         check("cyc_vec_valid", vec_valid, mv);
         check("cyc_dut_rst_n", dut_rst_n, (m_busy && m_rst_left == 0) || m_done);
         check("cyc_vec_cnt", vec_cnt, m_cnt);
         if (mv) check("cyc_vec_data", vec_data, m_vec);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_start(input logic [31:0] s, input logic [CNT_W-1:0] n);
      seed = s; num_vecs = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid();
      int c = 0;
      while (!vec_valid && c < 100) begin tick(); c++; end
      check("wait_valid", vec_valid, 1);
   endtask

   task automatic wait_done();
      int c = 0;
      while (!done && c < 300) begin tick(); c++; end
      check("wait_done", done, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dut_rst_n"}, dut_rst_n, 0);
      check({tag, "_vec_valid"}, vec_valid, 0);
      check({tag, "_vec_data"}, vec_data, 0);
      check({tag, "_vec_cnt"}, vec_cnt, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; abort = 1'b0; vec_ready = 1'b0;
      seed = '0; num_vecs = '0;
      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      // seed 0, one vector, ready high: reset window and first-valid timing
      vec_ready = 1'b1;
      do_start(32'd0, 1);
      check("t2_rstn_c0", dut_rst_n, 0);
      tick();
      check("t2_rstn_c1", dut_rst_n, 0);
      tick();
      check("t2_rstn_c2", dut_rst_n, 1);
      k = 2;
      while (!vec_valid && k < 40) begin tick(); k++; end
      check("t2_first_valid_cycle", k, 11);
      check("t1_chunk0", vec_data[31:0], 32'h0000_3039);
      check("t1_chunk1", vec_data[63:32], 32'hD3DC_167E);
      tick();
      check("t1_done", done, 1);
      check("t1_vec_cnt", vec_cnt, 1);
      check("t1_valid_low", vec_valid, 0);

      // back-pressure: ready low for 5 cycles in PRESENT
      vec_ready = 1'b0;
      do_start($urandom, 3);
      wait_valid();
      repeat (5) begin
         tick();
         check("t3_hold_valid", vec_valid, 1);
      end
      vec_ready = 1'b1;
      wait_done();
      check("t3_vec_cnt", vec_cnt, 3);

      // zero vectors: reset window then straight to done
      do_start($urandom, 0);
      check("t4_busy", busy, 1);
      tick();
      tick();
      check("t4_done", done, 1);
      check("t4_vec_cnt", vec_cnt, 0);
      check("t4_busy_low", busy, 0);

      // abort together with start while filling vector 2
      do_start($urandom, 3);
      k = 0;
      while (vec_cnt != 1 && k < 100) begin tick(); k++; end
      check("t5_cnt_before", vec_cnt, 1);
      repeat (3) tick();
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check("t5_valid", vec_valid, 0);
      check("t5_done", done, 0);
      check("t5_rstn", dut_rst_n, 0);
      check("t5_vec_cnt", vec_cnt, 1);
      check("t5_busy", busy, 0);
      tick();
      check("t5_start_dropped", busy, 0);

      // asynchronous reset while presenting with ready high
      vec_ready = 1'b0;
      do_start(32'd0, 1);
      wait_valid();
      #2;
      vec_ready = 1'b1;
      rst = 1'b1;
      #1;
      check_reset_vals("t6_rst");
      tick();
      rst = 1'b0;
      tick();
      do_start(32'd0, 1);
      wait_valid();
      check("t6_chunk0", vec_data[31:0], 32'h0000_3039);
      check("t6_chunk1", vec_data[63:32], 32'hD3DC_167E);
      tick();
      check("t6_done", done, 1);

      // randomized runs with back-pressure, stray starts and rare aborts
      for (int r = 0; r < 12; r++) begin
         do_start($urandom, CNT_W'($urandom_range(0, 4)));
         for (int c = 0; c < 400; c++) begin
            vec_ready = ($urandom_range(0, 9) < 7);
            abort     = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 29) == 0);
            seed      = $urandom;
            num_vecs  = CNT_W'($urandom_range(0, 4));
            tick();
            if (!busy) break;
         end
         start = 1'b0; abort = 1'b0;
         check("rand_run_ended", busy, 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
